// File: rtl/ifu_pkg.sv
// Shared types and constants for the RV32CoreF instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; a push and a pop in the same cycle are legal on a full FIFO.
module ifu_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited RAM requests, tag/output FIFOs, redirect with stale-response drop.
// Optional macro IFU_BYPASS_EN: forward a non-stale response straight to decode when the output FIFO is empty.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              instr_req,
  output logic              instr_write,
  output logic [DW/8-1:0]   instr_wstrb,
  output logic [AW-1:0]     instr_addr,
  output logic [DW-1:0]     instr_wdata,
  input  logic              instr_ready,
  input  logic              instr_rvalid,
  input  logic [DW-1:0]     instr_rdata,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic          req_q, req_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          stale_pend_q, stale_pend_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          accept, hold, rv, live, byp;
  logic [31:0]   pc_src;
  logic [SW-1:0] infl_nx, out_nx;

  logic [31:0]   tag_pc;
  logic [CW-1:0] tag_count, out_count;
  logic          tag_full, tag_empty, out_full, out_empty;
  logic          out_push, out_pop;
  fetch_entry_t  out_head, out_wdata;

  assign accept = req_q & instr_ready;
  assign hold   = req_q & ~instr_ready;
  // Responses with no outstanding tag (e.g. from before reset) are ignored.
  assign rv     = instr_rvalid & ~tag_empty;
  assign live   = rv & (drop_cnt_q == '0) & ~redirect;

`ifdef IFU_BYPASS_EN
  assign byp      = live & out_empty;
  assign if_valid = ~out_empty | byp;
  assign if_pc    = byp ? tag_pc : out_head.pc;
  assign if_instr = byp ? 32'(instr_rdata) : out_head.instr;
`else
  assign byp      = 1'b0;
  assign if_valid = ~out_empty;
  assign if_pc    = out_head.pc;
  assign if_instr = out_head.instr;
`endif

  assign out_push  = live & ~(byp & if_ready);
  assign out_pop   = ~out_empty & if_ready;
  assign out_wdata = '{pc: tag_pc, instr: 32'(instr_rdata)};

  assign instr_req   = req_q;
  assign instr_addr  = req_pc_q[AW+1:2];
  assign instr_write = 1'b0;
  assign instr_wstrb = '0;
  assign instr_wdata = '0;

  // Next request, PC and stale-drop bookkeeping.
  always_comb begin
    infl_nx      = SW'(tag_count) + SW'(accept) - SW'(rv);
    out_nx       = redirect ? '0 : SW'(out_count) + SW'(out_push) - SW'(out_pop);
    pc_src       = redirect ? (redirect_pc & ~32'h3) : pc_q;
    req_d        = 1'b0;
    req_pc_d     = req_pc_q;
    pc_d         = pc_src;
    stale_pend_d = stale_pend_q;
    drop_cnt_d   = drop_cnt_q;

    if (hold) begin
      req_d = 1'b1;
    end else if ((infl_nx + out_nx) < SW'(FIFO_DEPTH)) begin
      req_d    = 1'b1;
      req_pc_d = pc_src;
      pc_d     = pc_src + 32'(INSTR_BYTES);
    end

    if (accept && stale_pend_q) begin
      stale_pend_d = 1'b0;
      drop_cnt_d   = drop_cnt_d + CW'(1);
    end
    if (rv && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_d - CW'(1);

    // A held request becomes stale; everything already accepted is dropped.
    if (redirect) begin
      drop_cnt_d   = CW'(infl_nx);
      stale_pend_d = hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      stale_pend_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      req_q        <= req_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      stale_pend_q <= stale_pend_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  ifu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (accept),
    .pop_i   (rv),
    .wdata_i (req_pc_q),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .wdata_i (out_wdata),
    .rdata_o (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  // Credit accounting must make both overflows impossible.
  assert property (@(posedge clk) disable iff (rst) !(out_push && out_full && !out_pop));
  assert property (@(posedge clk) disable iff (rst) !(accept && tag_full && !rv));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and random-ready bench for ifu_fetch with an in-order one-cycle RAM model.
module tb_ifu_fetch;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          instr_req;
  logic          instr_write;
  logic [3:0]    instr_wstrb;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_wdata;
  logic          instr_ready;
  logic          instr_rvalid;
  logic [DW-1:0] instr_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int stab_err = 0;

  logic [31:0] dpc_q[$];
  logic [31:0] dins_q[$];
  logic [31:0] acc_q[$];
  logic        pend_prev;
  logic [AW-1:0] addr_prev;

  ifu_fetch #(.AW(AW), .DW(DW), .FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_req    (instr_req),
    .instr_write  (instr_write),
    .instr_wstrb  (instr_wstrb),
    .instr_addr   (instr_addr),
    .instr_wdata  (instr_wdata),
    .instr_ready  (instr_ready),
    .instr_rvalid (instr_rvalid),
    .instr_rdata  (instr_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [AW-1:0] a);
    return 32'h1300_0013 | ({20'h0, a} << 8);
  endfunction

  // RAM: accepts on req&ready, answers in order one cycle later.
  always @(posedge clk) begin
    instr_rvalid <= instr_req && instr_ready;
    instr_rdata  <= memw(instr_addr);
  end

  always @(negedge clk) begin
    if (rst) begin
      pend_prev = 1'b0;
    end else begin
      if (instr_req && instr_ready) acc_q.push_back(32'(instr_addr));
      if (if_valid && if_ready) begin
        dpc_q.push_back(if_pc);
        dins_q.push_back(if_instr);
      end
      if (pend_prev && !(instr_req && instr_addr == addr_prev)) stab_err++;
      pend_prev = instr_req && !instr_ready;
      addr_prev = instr_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic ifr);
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = rdy;
    if_ready = ifr;
    step(3);
    rst = 1'b0;
    dpc_q.delete();
    dins_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    instr_rvalid = 1'b0;
    instr_rdata  = '0;

    // Sequential fetch, full throughput downstream.
    do_reset(1'b1, 1'b1);
    check_eq("rst_req", 32'(instr_req), 32'd0);
    check_eq("rst_ifvalid", 32'(if_valid), 32'd0);
    step(1);
    check_eq("c1_req", 32'(instr_req), 32'd1);
    check_eq("c1_addr", 32'(instr_addr), 32'd0);
    step(1);
`ifdef IFU_BYPASS_EN
    check_eq("c2_byp_valid", 32'(if_valid), 32'd1);
    check_eq("c2_byp_pc", if_pc, 32'h0);
`else
    check_eq("c2_ifvalid", 32'(if_valid), 32'd0);
    step(1);
    check_eq("c3_ifvalid", 32'(if_valid), 32'd1);
    check_eq("c3_ifpc", if_pc, 32'h0);
`endif
    step(30);
    check_eq("seq_cnt", 32'(dpc_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pc", dpc_q[i], 32'(i * 4));
      check_eq("seq_instr", dins_q[i], memw(AW'(i)));
      check_eq("seq_addr", acc_q[i], 32'(i));
    end

    // Decode stalled: only FIFO_DEPTH requests go out.
    do_reset(1'b1, 1'b0);
    step(10);
    check_eq("stall_acc", 32'(acc_q.size()), 32'd2);
    check_eq("stall_req", 32'(instr_req), 32'd0);
    check_eq("stall_valid", 32'(if_valid), 32'd1);
    check_eq("stall_pc", if_pc, 32'h0);
    check_eq("stall_instr", if_instr, memw(AW'(0)));
    if_ready = 1'b1;
    step(20);
    check_eq("resume_pc0", dpc_q[0], 32'h0);
    check_eq("resume_pc1", dpc_q[1], 32'h4);
    check_eq("resume_addr", acc_q[2], 32'd2);

    // Redirect with responses in flight: all dropped.
    do_reset(1'b1, 1'b1);
    step(2);
    check_eq("rd1_addr", 32'(instr_addr), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step(1);
    redirect = 1'b0;
    check_eq("rd1_flush", 32'(if_valid), 32'd0);
    step(20);
    check_eq("rd1_cnt", 32'(dpc_q.size() >= 2), 32'd1);
    check_eq("rd1_pc", dpc_q[0], 32'h100);
    check_eq("rd1_instr", dins_q[0], memw(AW'(12'h40)));
    check_eq("rd1_pc2", dpc_q[1], 32'h104);

    // Redirect while a request is held: it stays up, its data is dropped.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 50 && !(instr_req && instr_addr == AW'(3)); i++) step(1);
    check_eq("rd2_find", 32'(instr_addr), 32'd3);
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect = 1'b0;
    acc_q.delete();
    dpc_q.delete();
    dins_q.delete();
    check_eq("rd2_hold_req", 32'(instr_req), 32'd1);
    check_eq("rd2_hold_addr", 32'(instr_addr), 32'd3);
    step(3);
    check_eq("rd2_hold_addr2", 32'(instr_addr), 32'd3);
    instr_ready = 1'b1;
    step(20);
    check_eq("rd2_acc_cnt", 32'(acc_q.size() >= 2), 32'd1);
    check_eq("rd2_acc0", acc_q[0], 32'd3);
    check_eq("rd2_acc1", acc_q[1], 32'h40);
    check_eq("rd2_pc", dpc_q[0], 32'h100);
    check_eq("rd2_instr", dins_q[0], memw(AW'(12'h40)));

    // Redirect together with rvalid and a completing handshake.
    do_reset(1'b1, 1'b1);
    step(3);
`ifndef IFU_BYPASS_EN
    check_eq("rd3_valid", 32'(if_valid), 32'd1);
    check_eq("rd3_pc", if_pc, 32'h0);
`endif
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0;
    step(20);
    check_eq("rd3_cnt", 32'(dpc_q.size() >= 3), 32'd1);
    check_eq("rd3_pc0", dpc_q[0], 32'h0);
    check_eq("rd3_pc1", dpc_q[1], 32'h200);
    check_eq("rd3_instr1", dins_q[1], memw(AW'(12'h80)));
    check_eq("rd3_pc2", dpc_q[2], 32'h204);

    // Random RAM ready and decode ready: strictly sequential delivery.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5000 && dpc_q.size() < 200; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    check_eq("rnd_cnt", 32'(dpc_q.size() >= 200), 32'd1);
    for (int i = 0; i < 200 && i < dpc_q.size(); i++) begin
      check_eq("rnd_pc", dpc_q[i], 32'(i * 4));
      check_eq("rnd_instr", dins_q[i], memw(AW'(i)));
    end
    check_eq("addr_stable", 32'(stab_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
